// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the two-requester ALU arbiter.
// Holds the FSM state enum, width defaults and the saturating counter helper.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, shared-ALU and response channels of alu_arbiter.
// The master modport is the surrounding system; the slave modport is the arbiter.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
);

  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the requester that was
// not granted last wins; a lone valid requester always wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant_id = 1'b0;
    grant    = 2'b00;
    if (valid == 2'b11) begin
      grant_id = ~last;
    end else if (valid[1]) begin
      grant_id = 1'b1;
    end
    if (|valid) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and returns the
// result on a single response channel (IDLE -> EXEC -> RESP).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  state_e            state_q;
  state_e            state_d;
  logic [1:0]        grant;
  logic              grant_id;
  logic              accept;
  logic              last_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_id_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

  rr_arb2 u_pick (
    .valid    ({bus.req1_valid, bus.req0_valid}),
    .last     (last_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Ready depends only on state, valids, the last-grant pointer and reset,
  // never on the ALU result or the response handshake.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (|grant)) begin
          accept         = 1'b1;
          bus.req0_ready = grant[0];
          bus.req1_ready = grant[1];
          state_d        = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_q doubles as the latched id of the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= grant_id;
        op_q   <= grant_id ? bus.req1_op : bus.req0_op;
        a_q    <= grant_id ? bus.req1_a  : bus.req0_a;
        b_q    <= grant_id ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= bus.alu_result;
        rsp_id_q   <= last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (accept && grant[0]) cnt0_q <= sat_inc(cnt0_q);
      if (accept && grant[1]) cnt1_q <= sat_inc(cnt1_q);
    end
  end

  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign grant_cnt0    = cnt0_q;
  assign grant_cnt1    = cnt1_q;

endmodule
